// File: rtl/bp_pkg.sv
// Shared definitions for the bimodal branch predictor.
//   bp_cnt_t    : 2-bit saturating counter state (MSB is the predicted direction)
//   BP_CNT_INIT : state every table entry takes on reset (weakly not-taken)
//   bp_index()  : word-aligned PC -> table index (PC[1:0] dropped, no tags)
package bp_pkg;

  localparam int BP_IDX_BITS = 6;
  localparam int BP_XLEN     = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_t;

  localparam bp_cnt_t BP_CNT_INIT = WNT;

  // Index is PC[idx_bits+1:2]; returned zero-extended so callers truncate to their table size.
  function automatic logic [BP_XLEN-1:0] bp_index(input logic [BP_XLEN-1:0] pc,
                                                  input int unsigned       idx_bits);
    logic [BP_XLEN-1:0] mask_s;
    mask_s = ~({BP_XLEN{1'b1}} << idx_bits);
    return (pc >> 2'd2) & mask_s;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for one 2-bit saturating direction counter.
//   cnt      : current counter state
//   taken    : resolved branch outcome (1 = taken)
//   next_cnt : counter state after learning from the outcome
module bp_sat_counter
  import bp_pkg::*;
(
  input  bp_cnt_t cnt,
  input  logic    taken,
  output bp_cnt_t next_cnt
);

  // Step towards ST on taken, towards SNT on not-taken, holding at either end.
  always_comb begin
    next_cnt = cnt;
    case (cnt)
      SNT:     next_cnt = taken ? WNT : SNT;
      WNT:     next_cnt = taken ? WT  : SNT;
      WT:      next_cnt = taken ? ST  : WNT;
      ST:      next_cnt = taken ? ST  : WT;
      default: next_cnt = BP_CNT_INIT;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a PC-indexed table of 2-bit saturating counters.
// Fetch looks up a direction one cycle after i_req; execute feeds back resolved
// branches, which train the table and raise a registered mispredict flag.
//   i_clk, i_rstn        : clock, asynchronous active-low reset
//   i_req, i_pc          : lookup request and PC from fetch
//   i_flush              : drops the response due next cycle (and any same-cycle request)
//   o_pred_valid/taken   : one-cycle prediction response
//   i_upd_valid/pc/taken : resolved branch, its PC and actual direction
//   i_upd_pred           : direction that was predicted for that branch
//   o_mispredict         : registered "resolved direction differed from prediction"
//   o_miss_count         : saturating count of mispredictions
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_BITS = BP_IDX_BITS,
  parameter int XLEN     = BP_XLEN,
  parameter int CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_req,
  input  logic [XLEN-1:0]  i_pc,
  output logic             o_pred_valid,
  output logic             o_pred_taken,
  input  logic             i_flush,
  input  logic             i_upd_valid,
  input  logic [XLEN-1:0]  i_upd_pc,
  input  logic             i_upd_taken,
  input  logic             i_upd_pred,
  output logic             o_mispredict,
  output logic [CNT_W-1:0] o_miss_count
);

  localparam int ENTRIES = 2 ** IDX_BITS;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  bp_cnt_t             cnt_r [ENTRIES];
  logic [XLEN-1:0]     upd_pc_s;
  logic                upd_taken_s;
  logic [IDX_BITS-1:0] upd_idx_s;
  logic [IDX_BITS-1:0] req_idx_s;
  bp_cnt_t             upd_next_s;
  bp_cnt_t             look_cnt_s;
  logic                accept_s;
  logic                miss_s;

  // Update-side inputs are gated by i_upd_valid so unknowns on an idle bus stay contained.
  assign upd_pc_s    = i_upd_valid ? i_upd_pc : {XLEN{1'b0}};
  assign upd_taken_s = i_upd_valid & i_upd_taken;
  assign miss_s      = i_upd_valid & (i_upd_taken ^ i_upd_pred);
  assign accept_s    = i_req & ~i_flush;

  assign upd_idx_s = IDX_BITS'(bp_index(BP_XLEN'(upd_pc_s), IDX_BITS));
  assign req_idx_s = IDX_BITS'(bp_index(BP_XLEN'(i_pc), IDX_BITS));

  bp_sat_counter u_sat_counter (
    .cnt      (cnt_r[upd_idx_s]),
    .taken    (upd_taken_s),
    .next_cnt (upd_next_s)
  );

  // Write-first bypass: a lookup hitting the entry being trained sees the trained value.
  always_comb begin
    look_cnt_s = cnt_r[req_idx_s];
    if (i_upd_valid && (upd_idx_s == req_idx_s)) begin
      look_cnt_s = upd_next_s;
    end else begin
      look_cnt_s = cnt_r[req_idx_s];
    end
  end

  // Counter table: flop array so every entry can be initialised by the async reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_r[i] <= BP_CNT_INIT;
      end
    end else if (i_upd_valid) begin
      cnt_r[upd_idx_s] <= upd_next_s;
    end
  end

  // Registered prediction response and mispredict reporting.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_pred_valid <= 1'b0;
      o_pred_taken <= 1'b0;
      o_mispredict <= 1'b0;
      o_miss_count <= {CNT_W{1'b0}};
    end else begin
      o_pred_valid <= accept_s;
      o_pred_taken <= accept_s & look_cnt_s[1];
      o_mispredict <= miss_s;
      if (miss_s && (o_miss_count != CNT_MAX)) begin
        o_miss_count <= o_miss_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor. A second instance with a 2-bit miss
// counter shares the stimulus so saturation of the statistics counter is reached.
module tb_branch_predictor;

  logic        i_clk;
  logic        i_rstn;
  logic        i_req;
  logic [31:0] i_pc;
  logic        i_flush;
  logic        i_upd_valid;
  logic [31:0] i_upd_pc;
  logic        i_upd_taken;
  logic        i_upd_pred;

  logic        o_pred_valid;
  logic        o_pred_taken;
  logic        o_mispredict;
  logic [31:0] o_miss_count;

  logic        s_pred_valid;
  logic        s_pred_taken;
  logic        s_mispredict;
  logic [1:0]  s_miss_count;

  int n_vec;
  int n_miss;

  branch_predictor #(.IDX_BITS(6), .XLEN(32), .CNT_W(32)) dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_req        (i_req),
    .i_pc         (i_pc),
    .o_pred_valid (o_pred_valid),
    .o_pred_taken (o_pred_taken),
    .i_flush      (i_flush),
    .i_upd_valid  (i_upd_valid),
    .i_upd_pc     (i_upd_pc),
    .i_upd_taken  (i_upd_taken),
    .i_upd_pred   (i_upd_pred),
    .o_mispredict (o_mispredict),
    .o_miss_count (o_miss_count)
  );

  branch_predictor #(.IDX_BITS(6), .XLEN(32), .CNT_W(2)) dut_sat (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_req        (i_req),
    .i_pc         (i_pc),
    .o_pred_valid (s_pred_valid),
    .o_pred_taken (s_pred_taken),
    .i_flush      (i_flush),
    .i_upd_valid  (i_upd_valid),
    .i_upd_pc     (i_upd_pc),
    .i_upd_taken  (i_upd_taken),
    .i_upd_pred   (i_upd_pred),
    .o_mispredict (s_mispredict),
    .o_miss_count (s_miss_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_req(input logic req, input logic [31:0] pc);
    i_req = req;
    i_pc  = pc;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic t, input logic p);
    i_upd_valid = v;
    i_upd_pc    = pc;
    i_upd_taken = t;
    i_upd_pred  = p;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    i_rstn  = 1'b0;
    i_flush = 1'b0;
    set_req(1'b0, 32'h0);
    set_upd(1'b0, 32'h0, 1'b0, 1'b0);

    // Reset state
    step();
    step();
    check_vec("rst_pred_valid", 32'(o_pred_valid), 32'd0);
    check_vec("rst_pred_taken", 32'(o_pred_taken), 32'd0);
    check_vec("rst_mispredict", 32'(o_mispredict), 32'd0);
    check_vec("rst_miss_count", o_miss_count, 32'd0);
    i_rstn = 1'b1;

    // First lookup of a fresh (WNT) entry
    set_req(1'b1, 32'h100);
    step();
    check_vec("lk0_valid", 32'(o_pred_valid), 32'd1);
    check_vec("lk0_taken", 32'(o_pred_taken), 32'd0);
    set_req(1'b0, 32'h0);
    step();
    check_vec("lk0_pulse", 32'(o_pred_valid), 32'd0);

    // Two taken updates predicted not-taken: WNT -> WT -> ST
    set_upd(1'b1, 32'h100, 1'b1, 1'b0);
    step();
    check_vec("up1_mis", 32'(o_mispredict), 32'd1);
    check_vec("up1_cnt", o_miss_count, 32'd1);
    step();
    check_vec("up2_mis", 32'(o_mispredict), 32'd1);
    check_vec("up2_cnt", o_miss_count, 32'd2);
    check_vec("up2_scnt", 32'(s_miss_count), 32'd2);
    set_upd(1'b0, 32'h0, 1'b0, 1'b0);
    set_req(1'b1, 32'h100);
    step();
    check_vec("lk_st_taken", 32'(o_pred_taken), 32'd1);
    set_req(1'b0, 32'h0);
    set_upd(1'b1, 32'h100, 1'b1, 1'b1);
    step();
    check_vec("up3_mis", 32'(o_mispredict), 32'd0);
    check_vec("up3_cnt", o_miss_count, 32'd2);

    // Four not-taken updates from ST, each with a bypassed lookup: WT, WNT, SNT, SNT
    for (int i = 0; i < 4; i++) begin
      set_upd(1'b1, 32'h100, 1'b0, 1'b1);
      set_req(1'b1, 32'h100);
      step();
      check_vec($sformatf("dec%0d_taken", i), 32'(o_pred_taken), (i == 0) ? 32'd1 : 32'd0);
      check_vec($sformatf("dec%0d_cnt", i), o_miss_count, 32'(3 + i));
    end
    check_vec("dec_scnt_sat", 32'(s_miss_count), 32'd3);
    // Climb back out of SNT: WNT (0) then WT (1)
    set_upd(1'b1, 32'h100, 1'b1, 1'b0);
    set_req(1'b1, 32'h100);
    step();
    check_vec("inc0_taken", 32'(o_pred_taken), 32'd0);
    step();
    check_vec("inc1_taken", 32'(o_pred_taken), 32'd1);
    check_vec("inc1_cnt", o_miss_count, 32'd8);

    // Same-cycle lookup and update on the same entry returns the updated direction
    set_upd(1'b1, 32'h204, 1'b1, 1'b0);
    set_req(1'b1, 32'h204);
    step();
    check_vec("byp_valid", 32'(o_pred_valid), 32'd1);
    check_vec("byp_taken", 32'(o_pred_taken), 32'd1);
    check_vec("byp_cnt", o_miss_count, 32'd9);
    set_upd(1'b0, 32'h0, 1'b0, 1'b0);
    set_req(1'b1, 32'h104);
    step();
    check_vec("alias_taken", 32'(o_pred_taken), 32'd1);
    // Different indices in the same cycle are independent
    set_req(1'b1, 32'h008);
    set_upd(1'b1, 32'h00C, 1'b1, 1'b1);
    step();
    check_vec("indep_taken", 32'(o_pred_taken), 32'd0);
    check_vec("indep_mis", 32'(o_mispredict), 32'd0);
    check_vec("indep_cnt", o_miss_count, 32'd9);
    set_upd(1'b0, 32'h0, 1'b0, 1'b0);
    set_req(1'b1, 32'h00F);
    step();
    check_vec("pclow_taken", 32'(o_pred_taken), 32'd1);

    // Update bus ignored while i_upd_valid is low
    set_upd(1'b0, 32'h008, 1'b1, 1'b0);
    set_req(1'b1, 32'h008);
    step();
    check_vec("novld_mis", 32'(o_mispredict), 32'd0);
    check_vec("novld_cnt", o_miss_count, 32'd9);
    check_vec("novld_taken", 32'(o_pred_taken), 32'd0);
    set_upd(1'b0, 32'h0, 1'b0, 1'b0);

    // Flush with a same-cycle request drops the response; table untouched
    set_req(1'b1, 32'h204);
    i_flush = 1'b1;
    step();
    check_vec("flush_valid", 32'(o_pred_valid), 32'd0);
    i_flush = 1'b0;
    step();
    check_vec("postflush_valid", 32'(o_pred_valid), 32'd1);
    check_vec("postflush_taken", 32'(o_pred_taken), 32'd1);
    // Back-to-back requests give back-to-back responses
    set_req(1'b1, 32'h100);
    step();
    check_vec("b2b0_valid", 32'(o_pred_valid), 32'd1);
    check_vec("b2b0_taken", 32'(o_pred_taken), 32'd1);
    set_req(1'b1, 32'h008);
    step();
    check_vec("b2b1_valid", 32'(o_pred_valid), 32'd1);
    check_vec("b2b1_taken", 32'(o_pred_taken), 32'd0);
    set_req(1'b0, 32'h0);
    step();
    check_vec("idle_valid", 32'(o_pred_valid), 32'd0);

    // Reset asserted between request and response
    set_req(1'b1, 32'h204);
    #2;
    i_rstn = 1'b0;
    step();
    check_vec("midrst_valid", 32'(o_pred_valid), 32'd0);
    check_vec("midrst_cnt", o_miss_count, 32'd0);
    check_vec("midrst_scnt", 32'(s_miss_count), 32'd0);
    i_rstn = 1'b1;
    step();
    check_vec("rerst_valid", 32'(o_pred_valid), 32'd1);
    check_vec("rerst_204", 32'(o_pred_taken), 32'd0);
    set_req(1'b1, 32'h100);
    step();
    check_vec("rerst_100", 32'(o_pred_taken), 32'd0);
    set_req(1'b0, 32'h0);

    // Miss counter saturation on the narrow instance
    set_upd(1'b1, 32'h300, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check_vec($sformatf("sat%0d_cnt", i), o_miss_count, 32'(i));
      check_vec($sformatf("sat%0d_scnt", i), 32'(s_miss_count), (i >= 3) ? 32'd3 : 32'(i));
    end
    set_upd(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check_vec("sat_hold_mis", 32'(s_mispredict), 32'd0);
    check_vec("sat_hold_scnt", 32'(s_miss_count), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
